// File: rtl/sad_min_tracker.sv
// Minimum-SAD tracker: walks a raster search window, keeps the smallest Sum and its (X, Y).
// Optional macro SAD_TIE_LAST_EN: on equal sums keep the latest raster position instead of the earliest.
module sad_min_tracker #(
    parameter int COORD_W = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [COORD_W-1:0]     WinCols,
    input  logic [COORD_W-1:0]     WinRows,
    input  logic                   SumValid,
    input  logic [31:0]            Sum,
    output logic [31:0]            MinSum,
    output logic [COORD_W-1:0]     MinX,
    output logic [COORD_W-1:0]     MinY,
    output logic                   MinValid,
    output logic                   Busy,
    output logic                   Done,
    output logic [2*COORD_W-1:0]   SampleCount
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [COORD_W-1:0]   COORD_ONE = COORD_W'(1);
    localparam logic [2*COORD_W-1:0] CNT_ONE   = (2*COORD_W)'(1);

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   cols_q, cols_d;
    logic [COORD_W-1:0]   rows_q, rows_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [COORD_W-1:0]   min_x_q, min_x_d;
    logic [COORD_W-1:0]   min_y_q, min_y_d;
    logic [31:0]          min_sum_q, min_sum_d;
    logic                 min_valid_q, min_valid_d;
    logic                 done_q, done_d;
    logic [2*COORD_W-1:0] cnt_q, cnt_d;

    logic better;
    logic last_col;
    logic last_row;

    // The first sample of a search always wins, whatever its value.
`ifdef SAD_TIE_LAST_EN
    assign better = !min_valid_q || (Sum <= min_sum_q);
`else
    assign better = !min_valid_q || (Sum < min_sum_q);
`endif

    assign last_col = (x_q == (cols_q - COORD_ONE));
    assign last_row = (y_q == (rows_q - COORD_ONE));

    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        x_d         = x_q;
        y_d         = y_q;
        min_x_d     = min_x_q;
        min_y_d     = min_y_q;
        min_sum_d   = min_sum_q;
        min_valid_d = min_valid_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;

        if (Start) begin
            cols_d      = WinCols;
            rows_d      = WinRows;
            x_d         = '0;
            y_d         = '0;
            cnt_d       = '0;
            min_sum_d   = '1;
            min_x_d     = '0;
            min_y_d     = '0;
            min_valid_d = 1'b0;
            if ((WinCols == '0) || (WinRows == '0)) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = SEARCH;
            end
        end else if ((state_q == SEARCH) && SumValid) begin
            if (better) begin
                min_sum_d   = Sum;
                min_x_d     = x_q;
                min_y_d     = y_q;
                min_valid_d = 1'b1;
            end
            cnt_d = cnt_q + CNT_ONE;
            if (last_col) begin
                x_d = '0;
                y_d = y_q + COORD_ONE;
            end else begin
                x_d = x_q + COORD_ONE;
            end
            if (last_col && last_row) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            min_x_q     <= '0;
            min_y_q     <= '0;
            min_sum_q   <= '1;
            min_valid_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            x_q         <= x_d;
            y_q         <= y_d;
            min_x_q     <= min_x_d;
            min_y_q     <= min_y_d;
            min_sum_q   <= min_sum_d;
            min_valid_q <= min_valid_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign MinSum      = min_sum_q;
    assign MinX        = min_x_q;
    assign MinY        = min_y_q;
    assign MinValid    = min_valid_q;
    assign Busy        = (state_q == SEARCH);
    assign Done        = done_q;
    assign SampleCount = cnt_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker: directed test-plan scenarios plus randomized windows against a history-based model.
// Compile with SAD_TIE_LAST_EN defined to check the tie-keeps-latest build.
module tb_sad_min_tracker;

    localparam int COORD_W = 8;
`ifdef SAD_TIE_LAST_EN
    localparam bit TIE_LAST = 1'b1;
`else
    localparam bit TIE_LAST = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [7:0]   WinCols = '0;
    logic [7:0]   WinRows = '0;
    logic         SumValid = 1'b0;
    logic [31:0]  Sum = '0;
    logic [31:0]  MinSum;
    logic [7:0]   MinX;
    logic [7:0]   MinY;
    logic         MinValid;
    logic         Busy;
    logic         Done;
    logic [15:0]  SampleCount;

    int ntests = 0;
    int nfail  = 0;

    sad_min_tracker #(.COORD_W(COORD_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .WinCols(WinCols), .WinRows(WinRows),
        .SumValid(SumValid), .Sum(Sum), .MinSum(MinSum), .MinX(MinX), .MinY(MinY),
        .MinValid(MinValid), .Busy(Busy), .Done(Done), .SampleCount(SampleCount)
    );

    always #5 Clk = ~Clk;

    logic [66:0] obs;
    assign obs = {MinSum, MinX, MinY, MinValid, Busy, Done, SampleCount};

    // Reference model: the window and the list of accepted sums since the last Start.
    logic [31:0] acc[$];
    int m_cols = 1;
    int m_rows = 1;
    bit m_search = 1'b0;
    bit m_done = 1'b0;

    function automatic void model_reset();
        acc.delete();
        m_cols = 1;
        m_rows = 1;
        m_search = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic logic [66:0] exp_vec();
        logic [31:0] mn;
        logic [7:0]  ex, ey;
        bit          ev;
        mn = '1; ex = '0; ey = '0; ev = 1'b0;
        foreach (acc[i]) begin
            if (!ev || acc[i] < mn || (TIE_LAST && acc[i] == mn)) begin
                mn = acc[i];
                ex = 8'(i % m_cols);
                ey = 8'(i / m_cols);
                ev = 1'b1;
            end
        end
        return {mn, ex, ey, ev, m_search, m_done, 16'(acc.size())};
    endfunction

    task automatic drive(input bit st, input int c, input int r, input bit v, input logic [31:0] s);
        Start = st; WinCols = 8'(c); WinRows = 8'(r); SumValid = v; Sum = s;
        @(posedge Clk);
        #1;
        Start = 1'b0; SumValid = 1'b0;
        m_done = 1'b0;
        if (st) begin
            m_cols = c; m_rows = r; acc.delete();
            m_search = (c != 0) && (r != 0);
            m_done = !m_search;
        end else if (v && m_search) begin
            acc.push_back(s);
            if (acc.size() == m_cols * m_rows) begin
                m_search = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        ntests++;
        if (obs !== exp_vec()) begin
            nfail++; $display("FAIL reset_state got %h want %h", obs, exp_vec());
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        ntests++;
        if (obs !== exp_vec()) begin
            nfail++; $display("FAIL reset_idle got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_raster_min();
        logic [31:0] sums [6] = '{32'd50, 32'd40, 32'd60, 32'd40, 32'd70, 32'd45};
        int dones = 0;
        drive(1, 3, 2, 0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(0, 3, 2, 1, sums[i]);
            else       drive(0, 3, 2, 0, 0);
            if (Done) dones++;
            ntests++;
            if (obs !== exp_vec()) begin
                nfail++; $display("FAIL raster_step%0d got %h want %h", i, obs, exp_vec());
            end
            if (i == 5) begin
                ntests++;
                if (MinSum !== 32'd40 || MinX !== (TIE_LAST ? 8'd0 : 8'd1) || MinY !== (TIE_LAST ? 8'd1 : 8'd0)
                    || SampleCount !== 16'd6 || Done !== 1'b1) begin
                    nfail++; $display("FAIL raster_final got sum=%0d x=%0d y=%0d cnt=%0d done=%b want sum=40 x=%0d y=%0d cnt=6 done=1",
                                      MinSum, MinX, MinY, SampleCount, Done, TIE_LAST ? 0 : 1, TIE_LAST ? 1 : 0);
                end
            end
        end
        ntests++;
        if (dones !== 1) begin
            nfail++; $display("FAIL raster_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_gaps();
        bit          vpat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [31:0] sums [4] = '{32'd9, 32'd8, 32'd7, 32'd6};
        int k = 0;
        int dones = 0;
        drive(1, 2, 2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i < 7 && vpat[i]) begin
                drive(0, 2, 2, 1, sums[k]);
                k++;
            end else begin
                drive(0, 2, 2, 0, 32'hDEAD);
            end
            if (Done) dones++;
            ntests++;
            if (obs !== exp_vec()) begin
                nfail++; $display("FAIL gaps_step%0d got %h want %h", i, obs, exp_vec());
            end
        end
        ntests++;
        if (MinSum !== 32'd6 || MinX !== 8'd1 || MinY !== 8'd1 || dones !== 1) begin
            nfail++; $display("FAIL gaps_final got sum=%0d x=%0d y=%0d dones=%0d want sum=6 x=1 y=1 dones=1",
                              MinSum, MinX, MinY, dones);
        end
    endtask

    task automatic test_restart();
        logic [31:0] sums [4] = '{32'd9, 32'd8, 32'd7, 32'd10};
        int dones = 0;
        drive(1, 4, 1, 0, 0);
        drive(0, 4, 1, 1, 5);
        if (Done) dones++;
        drive(0, 4, 1, 1, 3);
        if (Done) dones++;
        drive(1, 4, 1, 0, 0);
        if (Done) dones++;
        ntests++;
        if (obs !== exp_vec() || dones !== 0) begin
            nfail++; $display("FAIL restart_abort got %h dones=%0d want %h dones=0", obs, dones, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 4, 1, 1, sums[i]);
            if (Done) dones++;
            ntests++;
            if (obs !== exp_vec()) begin
                nfail++; $display("FAIL restart_step%0d got %h want %h", i, obs, exp_vec());
            end
        end
        ntests++;
        if (MinSum !== 32'd7 || MinX !== 8'd2 || MinY !== 8'd0 || dones !== 1) begin
            nfail++; $display("FAIL restart_final got sum=%0d x=%0d y=%0d dones=%0d want sum=7 x=2 y=0 dones=1",
                              MinSum, MinX, MinY, dones);
        end
    endtask

    task automatic test_start_collision();
        drive(1, 2, 1, 1, 1);
        ntests++;
        if (obs !== exp_vec() || SampleCount !== 16'd0) begin
            nfail++; $display("FAIL collision_discard got %h want %h", obs, exp_vec());
        end
        drive(0, 2, 1, 1, 20);
        drive(0, 2, 1, 1, 30);
        ntests++;
        if (obs !== exp_vec() || MinSum !== 32'd20 || SampleCount !== 16'd2) begin
            nfail++; $display("FAIL collision_final got sum=%0d cnt=%0d vec=%h want sum=20 cnt=2 vec=%h",
                              MinSum, SampleCount, obs, exp_vec());
        end
    endtask

    task automatic test_zero_dim();
        drive(1, 0, 3, 0, 0);
        ntests++;
        if (Done !== 1'b1 || MinValid !== 1'b0 || MinSum !== 32'hFFFF_FFFF || Busy !== 1'b0) begin
            nfail++; $display("FAIL zero_done got done=%b mv=%b sum=%h busy=%b want done=1 mv=0 sum=ffffffff busy=0",
                              Done, MinValid, MinSum, Busy);
        end
        drive(0, 0, 3, 1, 5);
        ntests++;
        if (obs !== exp_vec() || SampleCount !== 16'd0 || Done !== 1'b0) begin
            nfail++; $display("FAIL zero_ignore got %h want %h", obs, exp_vec());
        end
        drive(0, 0, 3, 0, 0);
        ntests++;
        if (obs !== exp_vec()) begin
            nfail++; $display("FAIL zero_hold got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        drive(1, 3, 3, 0, 0);
        drive(0, 3, 3, 1, 4);
        drive(0, 3, 3, 1, 2);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        ntests++;
        if (obs !== exp_vec()) begin
            nfail++; $display("FAIL async_reset got %h want %h", obs, exp_vec());
        end
        @(posedge Clk);
        #1;
        ntests++;
        if (obs !== exp_vec()) begin
            nfail++; $display("FAIL async_reset_hold got %h want %h", obs, exp_vec());
        end
        @(negedge Clk);
        Reset = 1'b0;
        drive(1, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 77);
        ntests++;
        if (obs !== exp_vec() || Done !== 1'b1 || MinSum !== 32'd77) begin
            nfail++; $display("FAIL async_restart got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int c = $urandom_range(1, 4);
            int r = $urandom_range(1, 4);
            int budget = 0;
            drive(1, c, r, 0, 0);
            while (m_search && budget < 200) begin
                if ($urandom_range(0, 39) == 0) begin
                    c = $urandom_range(1, 4);
                    r = $urandom_range(1, 4);
                    drive(1, c, r, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
                end else begin
                    drive(0, c, r, $urandom_range(0, 3) != 0, $urandom_range(0, 15));
                end
                budget++;
                ntests++;
                if (obs !== exp_vec()) begin
                    nfail++; $display("FAIL random_t%0d_c%0d got %h want %h", t, budget, obs, exp_vec());
                end
            end
            ntests++;
            if (m_search) begin
                nfail++; $display("FAIL random_t%0d_timeout got busy=%b want search finished", t, Busy);
            end
            drive(0, c, r, 1, 3);
            ntests++;
            if (obs !== exp_vec()) begin
                nfail++; $display("FAIL random_t%0d_after got %h want %h", t, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster_min();
        test_gaps();
        test_restart();
        test_start_collision();
        test_zero_dim();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Writeback-side consumer of the three-stage SAD pipeline. It takes each completed SAD sum leaving the third SAD stage and walks a raster-ordered search window of candidate positions. For each window it tracks the minimum sum and its (X, Y) coordinate, then raises a one-cycle Done pulse once the last candidate is accepted. Results hold stable until the next search is started.

## Interface
Parameters:
- COORD_W, 8, width of window dimensions and coordinates.

Ports (one clock; reset is asynchronous and active-high):
- Clk  input  1  pipeline clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high; forces all state and outputs to their reset values.
- Start  input  1  single-cycle request to begin a new search; samples WinCols/WinRows.
- WinCols  input  COORD_W  number of candidate columns per row.
- WinRows  input  COORD_W  number of candidate rows.
- SumValid  input  1  Sum carries a completed SAD result (driven from the final SAD stage's write-to-WB qualifier).
- Sum  input  32  SAD result, unsigned.
- MinSum  output  32  smallest Sum accepted in the current or last search.
- MinX  output  COORD_W  column of MinSum.
- MinY  output  COORD_W  row of MinSum.
- MinValid  output  1  at least one sample has been accepted since Start.
- Busy  output  1  high in SEARCH.
- Done  output  1  one-cycle pulse when the search completes.
- SampleCount  output  2*COORD_W  samples accepted since Start.

## Operation
- States: IDLE, SEARCH, DONE. Reset enters IDLE.
- Start in any state:
  - Latch WinCols/WinRows.
  - Clear the X/Y counters and SampleCount to 0.
  - Set MinSum to 32'hFFFF_FFFF and clear MinValid.
  - Enter SEARCH.
- Start with WinCols==0 or WinRows==0: skip SEARCH and enter DONE directly. Done pulses, MinValid stays 0.
- SEARCH, on SumValid (accepted sample):
  - Comparison is unsigned. Sum < MinSum, or MinValid==0, loads MinSum=Sum, MinX=X, MinY=Y and sets MinValid.
  - SampleCount increments.
  - If X==cols-1, X wraps to 0 and Y increments; otherwise X increments.
  - On the sample at X==cols-1 and Y==rows-1, the state moves to DONE.
- SumValid outside SEARCH is ignored: no counter or result change.
- Start and SumValid in the same cycle: Start wins and the sample is discarded.
- Start mid-SEARCH aborts the current search and restarts it. No Done is issued for the aborted search.
- In DONE, outputs hold until the next Start. DONE with no Start remains in DONE.
- Reset mid-search returns to IDLE immediately, with no Done.

## Timing
- Reset values:
  - MinSum=32'hFFFF_FFFF, MinX=0, MinY=0.
  - MinValid=0, Busy=0, Done=0, SampleCount=0.
- Latency from an accepted sample to updated MinSum/MinX/MinY/SampleCount: 1 cycle (registered at the accepting edge).
- The edge that accepts the final sample also registers the final results and Done=1. Done is high for exactly that one following cycle.
- Busy goes high the cycle after Start and low in the same cycle Done rises.
- The zero-dimension case raises Done the cycle after Start.
- One sample per cycle is sustained; there is no backpressure.

## Configuration
- SAD_TIE_LAST_EN:
  - Undefined: strict less-than comparison. On equal sums the earliest raster position is kept.
  - Defined: less-than-or-equal comparison. On equal sums the latest raster position is kept.
  - Nothing else differs.

## Test plan
- 3x2 window, Start, then back-to-back sums 50,40,60,40,70,45:
  - Default build: MinSum=40, MinX=1, MinY=0.
  - SAD_TIE_LAST_EN build: MinSum=40, MinX=0, MinY=1.
  - Both builds: Done pulses once, after the 6th sample; SampleCount=6.
- 2x2 window, sums with SumValid gaps (valid, idle, idle, valid, valid, idle, valid) of 9,8,7,6:
  - MinSum=6, MinX=1, MinY=1.
  - Done pulses only after the 4th valid sample.
- Restart mid-search: Start 4x1 window, accept 5 and 3, then Start again with 4x1 and feed 9,8,7,10:
  - No Done after the first pair.
  - Final MinSum=7, MinX=2, MinY=0.
- Start and SumValid(Sum=1) asserted together, then 2x1 window sums 20,30:
  - The Sum=1 sample is discarded.
  - MinSum=20, SampleCount=2.
- WinCols=0 with Start:
  - Done is high on the next cycle, MinValid=0, MinSum=32'hFFFF_FFFF.
  - A subsequent SumValid changes nothing.
- Reset asserted asynchronously mid-search, between clock edges:
  - All outputs return to reset values immediately, Busy=0, no Done.
  - A new Start works normally afterwards.
